seg_scanner: RTL and testbench

SEG_SCANNER -- requirements
Module: seg_scanner

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_scanner_if.sv | 27 ++
 rtl/bcd_to_seg.sv | 28 ++
 rtl/seg_scanner.sv | 128 ++++++++++++
 tb/tb_seg_scanner.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the seven-segment scanner
// Holds the active-low segment patterns ({g,f,e,d,c,b,a}), the number of
// stored BCD digits, the default refresh divider and the scan index type.
package seg_pkg;

  localparam int NUM_DIGITS          = 5;
  localparam int REFRESH_DIV_DEFAULT = 100000;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan position; SCAN_SIGN is the leftmost anode (position 3).
  typedef enum logic [1:0] {
    SCAN_D0   = 2'd0,
    SCAN_D1   = 2'd1,
    SCAN_D2   = 2'd2,
    SCAN_SIGN = 2'd3
  } scan_idx_e;

  function automatic scan_idx_e next_scan(input scan_idx_e s);
    case (s)
      SCAN_D0: return SCAN_D1;
      SCAN_D1: return SCAN_D2;
      SCAN_D2: return SCAN_SIGN;
      default: return SCAN_D0;
    endcase
  endfunction

endpackage

// File: rtl/seg_scanner_if.sv
// rtl/seg_scanner_if.sv - control and display bundle of the segment scanner
// master: drives load/bcd/neg/scroll_left/scroll_right, observes display.
// slave : the scanner; drives anode/seg/dp/window.
interface seg_scanner_if;
  import seg_pkg::*;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    neg;
  logic                    scroll_left;
  logic                    scroll_right;
  logic [3:0]              anode;
  logic [6:0]              seg;
  logic                    dp;
  logic [1:0]              window;

  modport master (
    output load, bcd, neg, scroll_left, scroll_right,
    input  anode, seg, dp, window
  );

  modport slave (
    input  load, bcd, neg, scroll_left, scroll_right,
    output anode, seg, dp, window
  );

endinterface

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD nibble to active-low segment decoder
// Ports: digit (4-bit nibble in), seg (7-bit {g,f,e,d,c,b,a} active-low out).
// Non-decimal nibbles (10..15) decode to 'E'.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg_scanner.sv
// rtl/seg_scanner.sv - 4-anode multiplexed display of a scrollable 5-digit value
// Ports: clk (rising edge), rst (async active-low), bus (seg_scanner_if.slave):
//   load/bcd/neg capture a value, scroll_left/scroll_right move the 3-digit
//   window, anode/seg/dp are the registered display drive, window the offset.
module seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  seg_scanner_if.slave  bus
);

  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic                    neg_q, neg_d;
  logic [1:0]              window_q, window_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  scan_idx_e               scan_q, scan_d;
  logic [3:0]              anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic [NUM_DIGITS-1:0]   zero_upto;
  logic [2:0]              digit_idx;
  logic [3:0]              sel_digit;
  logic                    sel_blank;
  logic [6:0]              dec_seg;

  // Stored value and scroll window; load wins over any scroll request.
  always_comb begin
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    window_d = window_q;
    if (bus.load) begin
      bcd_d    = bus.bcd;
      neg_d    = bus.neg;
      window_d = 2'd0;
    end else if (bus.scroll_left && !bus.scroll_right) begin
      if (window_q != 2'd2) window_d = window_q + 2'd1;
    end else if (bus.scroll_right && !bus.scroll_left) begin
      if (window_q != 2'd0) window_d = window_q - 2'd1;
    end
  end

  // Free-running refresh divider; never disturbed by load or scroll.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    scan_d = scan_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      scan_d = next_scan(scan_q);
    end
  end

  // zero_upto[i]: digit i and every more-significant digit are zero. A nibble
  // of 10..15 is nonzero, so it automatically stops blanking below it.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    zero_upto = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (bcd_q[4*i +: 4] == 4'd0);
      zero_upto[i] = all_zero;
    end
  end

  // Digit shown at the current anode; only meaningful for positions 0..2.
  assign digit_idx = {1'b0, window_q} + {1'b0, scan_q};

  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == 3'(i)) begin
        sel_digit = bcd_q[4*i +: 4];
        sel_blank = (i != 0) && zero_upto[i];
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  always_comb begin
    anode_d = ~(4'b0001 << scan_q);
    if (scan_q == SCAN_SIGN) begin
      seg_d = neg_q ? SEG_MINUS : SEG_BLANK;
    end else begin
      seg_d = sel_blank ? SEG_BLANK : dec_seg;
    end
    // Decimal point on the rightmost anode flags hidden lower digits.
    dp_d = !((scan_q == SCAN_D0) && (window_q != 2'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      window_q <= 2'd0;
      cnt_q    <= '0;
      scan_q   <= SCAN_D0;
      anode_q  <= 4'b1111;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      scan_q   <= scan_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.anode  = anode_q;
  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.window = window_q;

endmodule

// File: tb/tb_seg_scanner.sv
// tb/tb_seg_scanner.sv - scoreboard bench for seg_scanner with REFRESH_DIV=4
module tb_seg_scanner;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] PE = 7'b0000110;
  localparam logic [6:0] PM = 7'b0111111;
  localparam logic [6:0] PB = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scanner_if bus_if ();

  seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt;

  // Edges since reset release; the scan period is 16 edges with edge 1 on anode 0.
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  typedef struct {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] win;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every falling edge with pending expectations consumes one.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, " anode"},  32'(bus_if.anode),  32'(e.anode));
      chk({e.tag, " seg"},    32'(bus_if.seg),    32'(e.seg));
      chk({e.tag, " dp"},     32'(bus_if.dp),     32'(e.dp));
      chk({e.tag, " window"}, 32'(bus_if.window), 32'(e.win));
    end
  end

  // Queue one full scan period of expected outputs, starting at anode 0.
  task automatic frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0, input logic [1:0] win);
    logic [6:0] segs [4];
    int guard;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((edge_cnt % 16) != 1 && guard < 40);
    for (int j = 0; j < 16; j++) begin
      exp_t e;
      int p;
      p       = j / 4;
      e.anode = ~(4'b0001 << p);
      e.seg   = segs[p];
      e.dp    = (p == 0 && win != 2'd0) ? 1'b0 : 1'b1;
      e.win   = win;
      e.tag   = $sformatf("%s a%0d c%0d", tag, p, j);
      exp_q.push_back(e);
    end
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
    chk({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Load sampled on the last edge of a scan period.
  task automatic load_vec(input logic [19:0] v, input logic n, input logic sl, input logic sr);
    int guard;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while ((edge_cnt % 16) != 15 && guard < 40);
    bus_if.bcd          = v;
    bus_if.neg          = n;
    bus_if.load         = 1'b1;
    bus_if.scroll_left  = sl;
    bus_if.scroll_right = sr;
    @(posedge clk); #1;
    bus_if.load         = 1'b0;
    bus_if.scroll_left  = 1'b0;
    bus_if.scroll_right = 1'b0;
    chk($sformatf("load %h window", v), 32'(bus_if.window), 32'd0);
  endtask

  task automatic scroll(input logic sl, input logic sr);
    @(posedge clk); #1;
    bus_if.scroll_left  = sl;
    bus_if.scroll_right = sr;
    @(posedge clk); #1;
    bus_if.scroll_left  = 1'b0;
    bus_if.scroll_right = 1'b0;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, " anode"},  32'(bus_if.anode),  32'hF);
    chk({tag, " seg"},    32'(bus_if.seg),    32'(PB));
    chk({tag, " dp"},     32'(bus_if.dp),     32'd1);
    chk({tag, " window"}, 32'(bus_if.window), 32'd0);
  endtask

  task automatic chk_first_edge(input string tag);
    chk({tag, " anode"},  32'(bus_if.anode),  32'hE);
    chk({tag, " seg"},    32'(bus_if.seg),    32'(P0));
    chk({tag, " dp"},     32'(bus_if.dp),     32'd1);
    chk({tag, " window"}, 32'(bus_if.window), 32'd0);
  endtask

  initial begin
    bus_if.load         = 1'b0;
    bus_if.bcd          = '0;
    bus_if.neg          = 1'b0;
    bus_if.scroll_left  = 1'b0;
    bus_if.scroll_right = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_blank("reset");

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_first_edge("first edge");

    frame("zero", PB, PB, PB, P0, 2'd0);

    load_vec(20'h00123, 1'b0, 1'b0, 1'b0);
    frame("h123", PB, P1, P2, P3, 2'd0);

    load_vec(20'h00005, 1'b1, 1'b0, 1'b0);
    frame("neg5", PM, PB, PB, P5, 2'd0);

    load_vec(20'h000A7, 1'b0, 1'b0, 1'b0);
    frame("hA7", PB, PB, PE, P7, 2'd0);

    load_vec(20'h12345, 1'b0, 1'b0, 1'b0);
    frame("w0", PB, P3, P4, P5, 2'd0);

    scroll(1'b1, 1'b0);
    scroll(1'b1, 1'b0);
    scroll(1'b1, 1'b0);
    chk("left saturate", 32'(bus_if.window), 32'd2);
    frame("w2", PB, P1, P2, P3, 2'd2);

    scroll(1'b1, 1'b1);
    chk("both scroll", 32'(bus_if.window), 32'd2);
    scroll(1'b0, 1'b1);
    chk("scroll right", 32'(bus_if.window), 32'd1);
    frame("w1", PB, P2, P3, P4, 2'd1);

    load_vec(20'h12345, 1'b1, 1'b1, 1'b0);
    frame("load prio", PM, P3, P4, P5, 2'd0);

    scroll(1'b0, 1'b1);
    chk("right saturate", 32'(bus_if.window), 32'd0);

    scroll(1'b1, 1'b0);
    chk("pre-reset window", 32'(bus_if.window), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_blank("async reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_first_edge("re-release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
